// File: rtl/vec_pkg.sv
// Shared opcodes, FSM states and helpers for the vector add/sub engine.
// Define VEC_SUB_EN to make opcode 101 an element-wise subtract.
package vec_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_WRB  = 3'b010;
    localparam logic [2:0] OP_INCB = 3'b011;
    localparam logic [2:0] OP_WRA  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;
    localparam int INIT_ONE   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_e;

    function automatic int c_width(input int dw);
        return dw + 1;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
`ifdef VEC_SUB_EN
        return op <= OP_SUB;
`else
        return op <= OP_WRA;
`endif
    endfunction

    function automatic logic op_is_range(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/vec_ram.sv
// One write port plus two registered read-first read ports.
// The display port register clears on reset; contents never do.
module vec_ram
    import vec_pkg::*;
#(
    parameter int W     = 4,
    parameter int AW    = 10,
    parameter int DEPTH = 1024,
    parameter int INIT  = INIT_ZERO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] eaddr,
    output logic [W-1:0]  edata,
    input  logic [AW-1:0] daddr,
    output logic [W-1:0]  ddata
);

    typedef logic [W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            if (INIT == INIT_INDEX) m[i] = W'(i);
            else if (INIT == INIT_ONE) m[i] = W'(1);
            else m[i] = '0;
        end
        return m;
    endfunction

    mem_t mem = init_mem();

    logic [W-1:0] edata_q, edata_d;
    logic [W-1:0] ddata_q, ddata_d;

    always_comb begin
        edata_d = mem[eaddr];
        ddata_d = rst ? '0 : mem[daddr];
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        edata_q <= edata_d;
        ddata_q <= ddata_d;
    end

    assign edata = edata_q;
    assign ddata = ddata_q;

endmodule

// File: rtl/vec_addsub_engine.sv
// Command-driven element-wise vector add (and, with VEC_SUB_EN, subtract)
// over on-chip A/B/C RAMs, one element per clock.
module vec_addsub_engine
    import vec_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              btnc,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W:0]   c_out
);

    localparam int C_W = c_width(DATA_W);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              cv_q, cv_d;
    logic [ADDR_W-1:0] ca_q, ca_d;

    logic              accept;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] a_rd, b_rd;
    logic              a_we, b_we, c_we;
    logic [ADDR_W-1:0] b_wa;
    logic [DATA_W-1:0] b_wd;
    logic [C_W-1:0]    c_wd;
    logic [C_W-1:0]    c_eng_unused;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign accept    = cmd_valid && cmd_ready && !btnc;

    // Outside ISSUE the engine port looks up cmd_addr so INCB data is ready in FIN.
    assign eaddr = (state_q == S_ISSUE) ? base_q + cnt_q[ADDR_W-1:0]
                                        : cmd_addr;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cv_d    = (state_q == S_ISSUE);
        ca_d    = eaddr;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    base_d = cmd_addr;
                    len_d  = cmd_len;
                    cnt_d  = '0;
                    err_d  = !op_legal(cmd_op);
                    if (op_legal(cmd_op) && op_is_range(cmd_op)
                        && cmd_len != '0)
                        state_d = S_ISSUE;
                    else
                        state_d = S_FIN;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == len_q) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_we = accept && (cmd_op == OP_WRA);
        b_we = (accept && (cmd_op == OP_WRB))
            || ((state_q == S_FIN) && (op_q == OP_INCB) && !btnc);
        b_wa = (state_q == S_FIN) ? base_q : cmd_addr;
        b_wd = (state_q == S_FIN) ? b_rd + 1'b1 : cmd_data;
        c_we = cv_q && !btnc;
`ifdef VEC_SUB_EN
        if (op_q == OP_SUB)
            c_wd = {1'b0, a_rd} - {1'b0, b_rd};
        else
            c_wd = {1'b0, a_rd} + {1'b0, b_rd};
`else
        c_wd = {1'b0, a_rd} + {1'b0, b_rd};
`endif
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cv_q    <= 1'b0;
            ca_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cv_q    <= cv_d;
            ca_q    <= ca_d;
        end
    end

    vec_ram #(
        .W(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH), .INIT(INIT_INDEX)
    ) u_ram_a (
        .clk(clk), .rst(btnc),
        .we(a_we), .waddr(cmd_addr), .wdata(cmd_data),
        .eaddr(eaddr), .edata(a_rd),
        .daddr(rd_addr), .ddata(a_out)
    );

    vec_ram #(
        .W(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH), .INIT(INIT_ONE)
    ) u_ram_b (
        .clk(clk), .rst(btnc),
        .we(b_we), .waddr(b_wa), .wdata(b_wd),
        .eaddr(eaddr), .edata(b_rd),
        .daddr(rd_addr), .ddata(b_out)
    );

    vec_ram #(
        .W(C_W), .AW(ADDR_W), .DEPTH(DEPTH), .INIT(INIT_ZERO)
    ) u_ram_c (
        .clk(clk), .rst(btnc),
        .we(c_we), .waddr(ca_q), .wdata(c_wd),
        .eaddr(ca_q), .edata(c_eng_unused),
        .daddr(rd_addr), .ddata(c_out)
    );

endmodule
